dummy_pipe: RTL and testbench
=============================

DUMMY_PIPE -- requirements
Module: dummy_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, meaning payload width in bits (legal 1..1024).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of buffered entries (legal 1..16).
REQ-003 The block SHALL have port clk_i, input, 1, meaning the single clock; all logic rising-edge triggered.
REQ-004 The block SHALL have port reset_i, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port data_in_i, input, DATA_W, meaning upstream payload.
REQ-006 The block SHALL have port valid_in_i, input, 1, meaning upstream payload valid.
REQ-007 The block SHALL have port ready_out_o, output, 1, meaning block can accept upstream payload.
REQ-008 The block SHALL have port data_out_o, output, DATA_W, meaning downstream payload (registered).
REQ-009 The block SHALL have port valid_out_o, output, 1, meaning downstream payload valid.
REQ-010 The block SHALL have port ready_in_i, input, 1, meaning downstream can accept.
REQ-011 The block SHALL have port level_o, output, $clog2(DEPTH+1), meaning current entry count.

Function
REQ-012 The block SHALL accept an input transfer on a rising edge where valid_in_i and ready_out_o are both 1.
REQ-013 The block SHALL complete an output transfer on a rising edge where valid_out_o and ready_in_i are both 1.
REQ-014 ready_out_o SHALL be 1 exactly when level_o < DEPTH and reset_i is 0; no same-cycle pass-through when full.
REQ-015 valid_out_o SHALL be 1 exactly when level_o != 0.
REQ-016 data_out_o SHALL present the oldest stored entry; entries leave in acceptance order (FIFO).
REQ-017 Latency: a payload accepted into an empty block at edge N SHALL appear on data_out_o with valid_out_o=1 in the cycle after edge N.
REQ-018 data_out_o and valid_out_o SHALL stay stable while valid_out_o=1 and ready_in_i=0.
REQ-019 Simultaneous accept and output transfer SHALL leave level_o unchanged and keep ordering intact, including when level_o=1.
REQ-020 Read/write pointers SHALL wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL be handled correctly.
REQ-021 valid_in_i while ready_out_o=0 SHALL be ignored with no state change; ready_in_i while empty SHALL be ignored.
REQ-022 X or Z bits on data_in_i SHALL be stored and forwarded unmodified; X/Z on data_in_i while valid_in_i=0 SHALL not affect any output.
REQ-023 When data_out_o is not holding a valid entry it SHALL be all-zero.

Reset
REQ-024 While reset_i=1 at a rising edge: level_o=0, pointers=0, valid_out_o=0, data_out_o=all-zero, ready_out_o=0.
REQ-025 Reset mid-operation SHALL discard all stored entries; transfers on the reset edge SHALL not occur.
REQ-026 In the first cycle after reset deasserts, ready_out_o SHALL be 1 and valid_out_o 0.

Configuration
REQ-027 Macro DUMMY_PIPE_STATS_EN, when defined, SHALL add output port xfer_cnt_o, 32 bits, counting output transfers, reset to 0, wrapping 0xFFFFFFFF -> 0.
REQ-028 When DUMMY_PIPE_STATS_EN is undefined, xfer_cnt_o and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset held 3 cycles, then released -> ready_out_o=1, valid_out_o=0, level_o=0, data_out_o=0 next cycle.
REQ-030 Push 'h12345678 into empty, ready_in_i=1 -> data_out_o='h12345678, valid_out_o=1 one cycle later, then empty.
REQ-031 DEPTH=4, ready_in_i=0, push 1,2,3,4,5 back-to-back -> level_o=4, ready_out_o=0, value 5 not stored; release -> 1,2,3,4 in order.
REQ-032 level_o=1, simultaneous push 'hA and pop -> level_o stays 1, next output 'hA; run 20 mixed random pushes/pops with DEPTH=3 -> order preserved across wrap.
REQ-033 Push all-X then all-Z payloads -> forwarded bit-exact; X/Z on data_in_i with valid_in_i=0 -> no output change.
REQ-034 With DUMMY_PIPE_STATS_EN: 7 output transfers then reset_i pulse mid-stream -> xfer_cnt_o=7 before, 0 after, level_o=0.

Source files
------------

// File: rtl/dummy_pipe.sv
// dummy_pipe: DEPTH-entry FIFO pipeline stage with a valid/ready handshake on both sides.
// Define DUMMY_PIPE_STATS_EN to add the xfer_cnt_o output-transfer counter.
module dummy_pipe #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [DATA_W-1:0]          data_in_i,
  input  logic                       valid_in_i,
  output logic                       ready_out_o,
  output logic [DATA_W-1:0]          data_out_o,
  output logic                       valid_out_o,
  input  logic                       ready_in_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
`ifdef DUMMY_PIPE_STATS_EN
  ,
  output logic [31:0]                xfer_cnt_o
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              valid_out_q, valid_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              push_c;
  logic              pop_c;

  // Readiness is gated by reset directly so nothing is accepted on a reset edge.
  assign ready_out_o = ~full_q & ~reset_i;
  assign valid_out_o = valid_out_q;
  assign data_out_o  = data_out_q;
  assign level_o     = level_q;

  assign push_c = valid_in_i & ready_out_o;
  assign pop_c  = valid_out_q & ready_in_i;

  // Pointer, level and registered head-of-queue computation.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    full_d      = full_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = data_in_i;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    full_d      = (level_d == LVL_FULL);
    valid_out_d = (level_d != '0);

    // The next head is the slot being written this cycle when the queue was
    // empty, or held exactly one entry that is leaving alongside the push.
    if (!valid_out_d) begin
      data_out_d = '0;
    end else if (push_c && (rd_ptr_d == wr_ptr_q)) begin
      data_out_d = data_in_i;
    end else begin
      data_out_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  // Storage needs no reset; it is only read through valid pointers.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifdef DUMMY_PIPE_STATS_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (pop_c) begin
      xfer_cnt_d = xfer_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_dummy_pipe.sv
// Testbench for dummy_pipe: directed checks on a DEPTH=4 instance and a
// randomized queue-model comparison on a DEPTH=3 instance.
module tb_dummy_pipe;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_i;

  logic [DW-1:0] a_din;
  logic          a_vin, a_rdy, a_vout, a_rin;
  logic [DW-1:0] a_dout;
  logic [2:0]    a_level;

  logic [DW-1:0] b_din;
  logic          b_vin, b_rdy, b_vout, b_rin;
  logic [DW-1:0] b_dout;
  logic [1:0]    b_level;

`ifdef DUMMY_PIPE_STATS_EN
  logic [31:0]   a_cnt, b_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dummy_pipe #(.DATA_W(DW), .DEPTH(4)) u_a (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_in_i  (a_din),
    .valid_in_i (a_vin),
    .ready_out_o(a_rdy),
    .data_out_o (a_dout),
    .valid_out_o(a_vout),
    .ready_in_i (a_rin),
    .level_o    (a_level)
`ifdef DUMMY_PIPE_STATS_EN
    ,
    .xfer_cnt_o (a_cnt)
`endif
  );

  dummy_pipe #(.DATA_W(DW), .DEPTH(3)) u_b (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_in_i  (b_din),
    .valid_in_i (b_vin),
    .ready_out_o(b_rdy),
    .data_out_o (b_dout),
    .valid_out_o(b_vout),
    .ready_in_i (b_rin),
    .level_o    (b_level)
`ifdef DUMMY_PIPE_STATS_EN
    ,
    .xfer_cnt_o (b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic rdy, input logic vout,
                       input int lvl, input logic [DW-1:0] dout);
    chk({tag, ".ready"}, 32'(a_rdy), 32'(rdy));
    chk({tag, ".valid"}, 32'(a_vout), 32'(vout));
    chk({tag, ".level"}, 32'(a_level), 32'(lvl));
    chk({tag, ".data"},  a_dout, dout);
  endtask

  logic [DW-1:0] xv;
  logic [DW-1:0] zv;
  logic [DW-1:0] q[$];
  logic [DW-1:0] head;
  logic          do_push, do_pop;

  initial begin
    xv = 'x;
    zv = 'z;
    reset_i = 1'b1;
    a_din = '0; a_vin = 1'b0; a_rin = 1'b0;
    b_din = '0; b_vin = 1'b0; b_rin = 1'b0;

    // Reset held three cycles, with traffic offered that must be ignored.
    a_vin = 1'b1; a_rin = 1'b1; a_din = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk_a("in_reset", 1'b0, 1'b0, 0, '0);
    a_vin = 1'b0; a_rin = 1'b0;
    reset_i = 1'b0;
    #1;
    chk("rel.ready_now", 32'(a_rdy), 32'd1);
    tick();
    chk_a("post_reset", 1'b1, 1'b0, 0, '0);

    // Single push into empty, popped the following cycle.
    a_din = 32'h1234_5678; a_vin = 1'b1; a_rin = 1'b1;
    tick();
    a_vin = 1'b0;
    chk_a("single", 1'b1, 1'b1, 1, 32'h1234_5678);
    tick();
    chk_a("single_drain", 1'b1, 1'b0, 0, '0);

    // Fill to DEPTH with downstream stalled; the fifth value is refused.
    a_rin = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      a_din = 32'(i); a_vin = 1'b1;
      chk($sformatf("fill%0d.ready", i), 32'(a_rdy), (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    a_vin = 1'b0;
    chk_a("full", 1'b0, 1'b1, 4, 32'd1);
    tick();
    chk_a("full_stall", 1'b0, 1'b1, 4, 32'd1);
    a_rin = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain%0d.data", k), a_dout, 32'(k));
      chk($sformatf("drain%0d.valid", k), 32'(a_vout), 32'd1);
      tick();
    end
    chk_a("drained", 1'b1, 1'b0, 0, '0);

    // Simultaneous push and pop at level 1.
    a_rin = 1'b0; a_din = 32'h55; a_vin = 1'b1;
    tick();
    a_din = 32'hA; a_rin = 1'b1;
    chk("lvl1.before", a_dout, 32'h55);
    tick();
    a_vin = 1'b0; a_rin = 1'b0;
    chk_a("lvl1.after", 1'b1, 1'b1, 1, 32'hA);
    a_rin = 1'b1;
    tick();
    // ready_in while empty is ignored
    tick();
    chk_a("pop_empty", 1'b1, 1'b0, 0, '0);

    // X and Z payloads are forwarded; junk with valid low changes nothing.
    a_rin = 1'b0; a_din = xv; a_vin = 1'b1;
    tick();
    a_din = zv;
    tick();
    a_vin = 1'b0; a_din = xv;
    chk("xz.level", 32'(a_level), 32'd2);
    chk("xz.first", a_dout, xv);
    tick();
    a_din = zv;
    tick();
    chk("xz.idle_data", a_dout, xv);
    chk("xz.idle_level", 32'(a_level), 32'd2);
    a_rin = 1'b1;
    tick();
    chk("xz.second", a_dout, zv);
    tick();
    chk_a("xz.drained", 1'b1, 1'b0, 0, '0);

    // Stream seven entries through, stall with two queued, then reset mid-stream.
    a_rin = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_din = 32'h100 + 32'(i); a_vin = 1'b1;
      tick();
      chk($sformatf("stream%0d", i), a_dout, 32'h100 + 32'(i));
    end
    a_vin = 1'b0;
    tick();
    a_rin = 1'b0; a_din = 32'h200; a_vin = 1'b1;
    tick();
    a_din = 32'h201;
    tick();
    a_vin = 1'b0;
    chk("pre_rst.level", 32'(a_level), 32'd2);
`ifdef DUMMY_PIPE_STATS_EN
    chk("pre_rst.cnt", a_cnt, 32'd7);
`endif
    reset_i = 1'b1; a_vin = 1'b1; a_rin = 1'b1; a_din = 32'h300;
    tick();
    reset_i = 1'b0; a_vin = 1'b0; a_rin = 1'b0;
    #1;
    chk_a("mid_rst", 1'b1, 1'b0, 0, '0);
`ifdef DUMMY_PIPE_STATS_EN
    chk("mid_rst.cnt", a_cnt, 32'd0);
`endif

    // Randomized traffic on the DEPTH=3 instance against a queue model.
    q.delete();
    for (int c = 0; c < 300; c++) begin
      b_vin = 1'($urandom_range(0, 1));
      b_rin = ($urandom_range(0, 2) != 0);
      b_din = $urandom;
      head = (q.size() != 0) ? q[0] : '0;
      chk($sformatf("rnd%0d.level", c), 32'(b_level), 32'(q.size()));
      chk($sformatf("rnd%0d.valid", c), 32'(b_vout), 32'(q.size() != 0));
      chk($sformatf("rnd%0d.ready", c), 32'(b_rdy), 32'(q.size() < 3));
      chk($sformatf("rnd%0d.data", c), b_dout, head);
      do_push = b_vin && (q.size() < 3);
      do_pop  = b_rin && (q.size() != 0);
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(b_din);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
